ap_fifo_stream_tester: RTL

- Shell-side traffic source and checker for one HLS `ap_fifo` channel pair.
- Takes the place of the Xillybus FIFO end in front of a user IP: it drives the IP's input FIFO port, sinks the IP's output FIFO port, and generates a deterministic counting pattern.
- For a loopback-style IP, it compares each returned word against the same pattern and counts mismatches.
- Used for on-board self-test of each channel slot without host traffic.

---
 rtl/ap_fifo_stream_tester_if.sv | 30 +++
 rtl/ap_fifo_stream_tester.sv | 113 +++++++++++
 2 files changed

// File: rtl/ap_fifo_stream_tester_if.sv
// FIFO channel pair between the stream tester and the user IP (HLS ap_fifo naming).
// The master side is the tester, which sources in_V_V and sinks out_V_V.
interface ap_fifo_stream_tester_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] in_V_V_dout;
    logic              in_V_V_empty_n;
    logic              in_V_V_read;
    logic [DATA_W-1:0] out_V_V_din;
    logic              out_V_V_full_n;
    logic              out_V_V_write;

    modport master (
        output in_V_V_dout,
        output in_V_V_empty_n,
        input  in_V_V_read,
        input  out_V_V_din,
        output out_V_V_full_n,
        input  out_V_V_write
    );

    modport slave (
        input  in_V_V_dout,
        input  in_V_V_empty_n,
        output in_V_V_read,
        output out_V_V_din,
        input  out_V_V_full_n,
        output out_V_V_write
    );
endinterface

// File: rtl/ap_fifo_stream_tester.sv
// Counting-pattern source and loopback checker for one ap_fifo channel pair.
// Optional sink stalls: define AP_FIFO_STREAM_TESTER_BACKPRESSURE_EN.
module ap_fifo_stream_tester #(
    parameter int DATA_W  = 128,
    parameter int COUNT_W = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   start,
    input  logic [COUNT_W-1:0]     num_words,
    ap_fifo_stream_tester_if.master fifo,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_W-1:0]     rx_count,
    output logic [COUNT_W-1:0]     err_count
);
    localparam int LANES = DATA_W / 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [COUNT_W-1:0] words_q;
    logic [COUNT_W-1:0] tx_idx;
    logic [COUNT_W-1:0] rx_idx;
    logic [COUNT_W-1:0] err_q;
    logic               sink_ready;
    logic               pop;
    logic               push;
    logic               mismatch;

    // Lane i of word k carries k[31:0] + i; lane 0 sits at the LSBs.
    function automatic logic [DATA_W-1:0] pattern(input logic [COUNT_W-1:0] k);
        logic [DATA_W-1:0] w;
        logic [31:0]       base;
        base = 32'(k);
        w    = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*32 +: 32] = base + 32'(i);
        end
        return w;
    endfunction

`ifdef AP_FIFO_STREAM_TESTER_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11, free-running to stall the sink pseudo-randomly.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign sink_ready = lfsr[0];
`else
    assign sink_ready = 1'b1;
`endif

    assign fifo.in_V_V_empty_n = (state == RUN) && (tx_idx < words_q);
    assign fifo.out_V_V_full_n = (state == RUN) && (rx_idx < words_q) && sink_ready;
    assign fifo.in_V_V_dout    = pattern(tx_idx);

    assign pop      = fifo.in_V_V_read && fifo.in_V_V_empty_n;
    assign push     = fifo.out_V_V_write && fifo.out_V_V_full_n;
    assign mismatch = (fifo.out_V_V_din != pattern(rx_idx));

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (num_words == '0) ? DONE : RUN;
            RUN:  if (push && (rx_idx + COUNT_W'(1) == words_q)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            words_q <= '0;
            tx_idx  <= '0;
            rx_idx  <= '0;
            err_q   <= '0;
        end else if (state == IDLE && start) begin
            words_q <= num_words;
            tx_idx  <= '0;
            rx_idx  <= '0;
            err_q   <= '0;
        end else begin
            if (pop) tx_idx <= tx_idx + COUNT_W'(1);
            if (push) begin
                rx_idx <= rx_idx + COUNT_W'(1);
                if (mismatch && (err_q != '1)) err_q <= err_q + COUNT_W'(1);
            end
        end
    end

    // Every accepted word advances rx_idx, so it doubles as the visible word count.
    assign rx_count  = rx_idx;
    assign err_count = err_q;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
endmodule
